c17_pipe_arb: RTL and testbench

Two-requester arbiter and sequencer sharing one bit-level-pipelined c17 datapath (e.g. `c17_s2`). Grants one input vector per cycle to the datapath, tracks each in-flight vector's owner in a tag pipeline matched to the datapath latency, and returns results to per-requester response FIFOs. Credit-based issue means the unstallable datapath never produces a result with nowhere to go.

---
 rtl/c17_pipe_arb_if.sv | 33 +++
 rtl/c17_pipe_arb.sv | 168 ++++++++++++++++
 tb/tb_c17_pipe_arb.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c17_pipe_arb_if.sv
// Request/response/datapath bundle for c17_pipe_arb.
// master = requesters, consumers and the external c17 datapath; slave = arbiter.
interface c17_pipe_arb_if;
    logic       req0_valid;
    logic       req1_valid;
    logic       req0_ready;
    logic       req1_ready;
    logic [4:0] req0_data;
    logic [4:0] req1_data;
    logic       rsp0_valid;
    logic       rsp1_valid;
    logic       rsp0_ready;
    logic       rsp1_ready;
    logic [1:0] rsp0_data;
    logic [1:0] rsp1_data;
    logic [4:0] dp_in;
    logic [1:0] dp_out;
    logic       busy;

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data,
        output rsp0_ready, rsp1_ready, dp_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp0_data, rsp1_data, dp_in, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data,
        input  rsp0_ready, rsp1_ready, dp_out,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp0_data, rsp1_data, dp_in, busy
    );
endinterface

// File: rtl/c17_pipe_arb.sv
// Two-requester credit-based arbiter feeding one pipelined c17 datapath.
// Define C17_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 wins ties.
module c17_pipe_arb #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    c17_pipe_arb_if.slave bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_O = OW'(FIFO_DEPTH);

    typedef enum logic { REQ0 = 1'b0, REQ1 = 1'b1 } req_id_e;

    logic [1:0]    req_valid;
    logic [4:0]    req_data [2];
    logic [1:0]    rsp_ready;
    logic [1:0]    eligible;
    logic [1:0]    grant;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic          grant_any;
    req_id_e       grant_id;
    logic          tie_to_1;

    logic [CW-1:0] fifo_count [2];
    logic [CW-1:0] inflight   [2];
    logic [AW-1:0] wr_ptr     [2];
    logic [AW-1:0] rd_ptr     [2];
    logic [1:0]    fifo_mem   [2][FIFO_DEPTH];

    logic          tag_valid [LATENCY];
    req_id_e       tag_id    [LATENCY];
    logic          exit_valid;
    req_id_e       exit_id;
    logic          any_tag;

`ifdef C17_ARB_RR_EN
    req_id_e       last_grant;
`endif

    assign req_valid   = {bus.req1_valid, bus.req0_valid};
    assign req_data[0] = bus.req0_data;
    assign req_data[1] = bus.req1_data;
    assign rsp_ready   = {bus.rsp1_ready, bus.rsp0_ready};

    // Credit check uses registered counts only, so a pop frees credit one cycle later.
    // rst_n gating keeps ready/dp_in low while reset is held.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            eligible[i] = rst_n && req_valid[i] &&
                          (({1'b0, fifo_count[i]} + {1'b0, inflight[i]}) < DEPTH_O);
        end
    end

`ifdef C17_ARB_RR_EN
    assign tie_to_1 = (last_grant == REQ0);
`else
    assign tie_to_1 = 1'b0;
`endif

    always_comb begin
        grant     = '0;
        grant[1]  = eligible[1] && (!eligible[0] || tie_to_1);
        grant[0]  = eligible[0] && !grant[1];
        grant_any = grant[0] || grant[1];
        grant_id  = grant[1] ? REQ1 : REQ0;
    end

    always_comb begin
        bus.dp_in = '0;
        if (grant[0]) begin
            bus.dp_in = req_data[0];
        end else if (grant[1]) begin
            bus.dp_in = req_data[1];
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

`ifdef C17_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ1;
        end else if (grant_any) begin
            last_grant <= grant_id;
        end
    end
`endif

    // Owner tags travel alongside the vectors; the last stage lines up with dp_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                tag_valid[k] <= 1'b0;
                tag_id[k]    <= REQ0;
            end
        end else begin
            tag_valid[0] <= grant_any;
            tag_id[0]    <= grant_id;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_id[k]    <= tag_id[k-1];
            end
        end
    end

    assign exit_valid = tag_valid[LATENCY-1];
    assign exit_id    = tag_id[LATENCY-1];

    always_comb begin
        push    = '0;
        push[0] = exit_valid && (exit_id == REQ0);
        push[1] = exit_valid && (exit_id == REQ1);
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            pop[i] = (fifo_count[i] != '0) && rsp_ready[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_count[i] <= '0;
                inflight[i]   <= '0;
                wr_ptr[i]     <= '0;
                rd_ptr[i]     <= '0;
                for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
                    fifo_mem[i][j] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (push[i]) begin
                    fifo_mem[i][wr_ptr[i]] <= bus.dp_out;
                    wr_ptr[i]              <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                fifo_count[i] <= fifo_count[i] + CW'(push[i]) - CW'(pop[i]);
                inflight[i]   <= inflight[i] + CW'(grant[i]) - CW'(push[i]);
            end
        end
    end

    assign bus.rsp0_valid = (fifo_count[0] != '0);
    assign bus.rsp1_valid = (fifo_count[1] != '0);
    assign bus.rsp0_data  = fifo_mem[0][rd_ptr[0]];
    assign bus.rsp1_data  = fifo_mem[1][rd_ptr[1]];

    always_comb begin
        any_tag = 1'b0;
        for (int unsigned k = 0; k < LATENCY; k++) begin
            any_tag = any_tag | tag_valid[k];
        end
    end

    assign bus.busy = any_tag || (fifo_count[0] != '0) || (fifo_count[1] != '0);
endmodule

// File: tb/tb_c17_pipe_arb.sv
// Self-checking bench for c17_pipe_arb with a behavioural pipelined c17 datapath.
// Expected grant pattern on ties follows C17_ARB_RR_EN.
module tb_c17_pipe_arb;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    c17_pipe_arb_if bus ();

    c17_pipe_arb #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [1:0] c17(input logic [4:0] v);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
        {n1, n2, n3, n6, n7} = v;
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

    // Unresettable datapath: vectors in flight across a reset still emerge.
    logic [1:0] dp_pipe [LAT];
    always_ff @(posedge clk) begin
        dp_pipe[0] <= c17(bus.dp_in);
        for (int unsigned k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
    end
    assign bus.dp_out = dp_pipe[LAT-1];

    typedef struct {
        logic [4:0] data;
        logic       id;
        logic [1:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic id, input logic v, input logic [4:0] d);
        if (id) begin
            bus.req1_valid = v;
            bus.req1_data  = d;
        end else begin
            bus.req0_valid = v;
            bus.req0_data  = d;
        end
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, bus.busy, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rdy"}, {bus.req1_ready, bus.req0_ready}, 0);
        check({name, "_rspv"}, {bus.rsp1_valid, bus.rsp0_valid}, 0);
        check({name, "_rspd"}, {bus.rsp1_data, bus.rsp0_data}, 0);
        check({name, "_dpin"}, bus.dp_in, 0);
        check({name, "_busy"}, bus.busy, 0);
    endtask

    logic [1:0] exp_q0 [$];
    logic [1:0] exp_q1 [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc0;
        logic [1:0]  want;

        tbl[0] = '{5'b11111, 1'b0, 2'b10};
        tbl[1] = '{5'b01010, 1'b1, 2'b11};
        tbl[2] = '{5'b00111, 1'b0, 2'b00};
        tbl[3] = '{5'b11000, 1'b1, 2'b11};
        tbl[4] = '{5'b00001, 1'b0, 2'b01};
        tbl[5] = '{5'b10100, 1'b1, 2'b10};
        tbl[6] = '{5'b01100, 1'b0, 2'b11};
        tbl[7] = '{5'b00110, 1'b1, 2'b00};

        rst_n          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_data  = '0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single-vector issue/return latency for each table entry
        for (int unsigned n = 0; n < 8; n++) begin
            @(negedge clk);
            drive_req(tbl[n].id, 1'b1, tbl[n].data);
            #1;
            check("tbl_ready", tbl[n].id ? bus.req1_ready : bus.req0_ready, 1);
            check("tbl_dp_in", bus.dp_in, tbl[n].data);
            @(negedge clk);
            drive_req(tbl[n].id, 1'b0, 5'b0);
            #1;
            check("tbl_dp_idle", bus.dp_in, 0);
            @(negedge clk); #1;
            check("tbl_early", tbl[n].id ? bus.rsp1_valid : bus.rsp0_valid, 0);
            @(negedge clk); #1;
            check("tbl_rspv", tbl[n].id ? bus.rsp1_valid : bus.rsp0_valid, 1);
            check("tbl_rspd", tbl[n].id ? bus.rsp1_data : bus.rsp0_data, tbl[n].exp);
            check("tbl_other", tbl[n].id ? bus.rsp0_valid : bus.rsp1_valid, 0);
        end
        wait_idle("tbl_idle");

        // Back-to-back on requester 1
        @(negedge clk);
        drive_req(1'b1, 1'b1, 5'b00000);
        #1 check("b2b_rdy0", bus.req1_ready, 1);
        @(negedge clk);
        drive_req(1'b1, 1'b1, 5'b10101);
        #1 check("b2b_rdy1", bus.req1_ready, 1);
        check("b2b_dpin", bus.dp_in, 5'b10101);
        @(negedge clk);
        drive_req(1'b1, 1'b0, 5'b0);
        @(negedge clk); #1;
        check("b2b_v0", bus.rsp1_valid, 1);
        check("b2b_d0", bus.rsp1_data, 2'b00);
        @(negedge clk); #1;
        check("b2b_v1", bus.rsp1_valid, 1);
        check("b2b_d1", bus.rsp1_data, 2'b11);
        @(negedge clk); #1;
        check("b2b_v2", bus.rsp1_valid, 0);
        wait_idle("b2b_idle");

        // Both requesters valid every cycle
        for (int unsigned c = 0; c < 8; c++) begin
            @(negedge clk);
            drive_req(1'b0, 1'b1, 5'b00111);
            drive_req(1'b1, 1'b1, 5'b11000);
            #1;
`ifdef C17_ARB_RR_EN
            check("tie_g0", bus.req0_ready, (c % 2 == 0) ? 1 : 0);
            check("tie_g1", bus.req1_ready, (c % 2 == 1) ? 1 : 0);
`else
            check("tie_g0", bus.req0_ready, 1);
            check("tie_g1", bus.req1_ready, 0);
`endif
        end
        @(negedge clk);
        drive_req(1'b0, 1'b0, 5'b0);
        drive_req(1'b1, 1'b0, 5'b0);
        #1 wait_idle("tie_idle");

        // Backpressure on requester 0
        bus.rsp0_ready = 1'b0;
        acc0 = 0;
        for (int unsigned c = 0; c < 12; c++) begin
            @(negedge clk);
            drive_req(1'b0, 1'b1, 5'b11111);
            drive_req(1'b1, 1'b1, 5'b01010);
            #1;
            if (bus.req0_ready) acc0++;
            if (c >= 8) begin
                check("bp_rdy0_off", bus.req0_ready, 0);
                check("bp_rdy1_on", bus.req1_ready, 1);
            end
        end
        check("bp_accepts", acc0, 4);
        @(negedge clk);
        bus.rsp0_ready = 1'b1;
        #1;
        check("bp_pop_v", bus.rsp0_valid, 1);
        check("bp_pop_d", bus.rsp0_data, 2'b10);
        check("bp_same_cyc", bus.req0_ready, 0);
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        #1 check("bp_credit", bus.req0_ready, 1);
        @(negedge clk); #1;
        check("bp_one_only", bus.req0_ready, 0);
        drive_req(1'b0, 1'b0, 5'b0);
        drive_req(1'b1, 1'b0, 5'b0);
        bus.rsp0_ready = 1'b1;
        #1 wait_idle("bp_idle");

        // Asynchronous reset while vectors are in flight
        @(negedge clk);
        drive_req(1'b0, 1'b1, 5'b10101);
        @(negedge clk);
        drive_req(1'b0, 1'b1, 5'b01010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        drive_req(1'b0, 1'b0, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            check("rst_after_v", {bus.rsp1_valid, bus.rsp0_valid}, 0);
            check("rst_after_busy", bus.busy, 0);
        end

        // Random traffic against the c17 model
        for (int unsigned c = 0; c < 10000; c++) begin
            @(negedge clk);
            bus.req0_valid = ($urandom_range(99) < 70);
            bus.req1_valid = ($urandom_range(99) < 70);
            bus.req0_data  = 5'($urandom);
            bus.req1_data  = 5'($urandom);
            bus.rsp0_ready = ($urandom_range(99) < 60);
            bus.rsp1_ready = ($urandom_range(99) < 60);
            #1;
            check("rnd_one_grant", bus.req0_ready & bus.req1_ready, 0);
            if (bus.req0_ready && !bus.req0_valid) check("rnd_rdy0_no_valid", 1, 0);
            if (bus.req1_ready && !bus.req1_valid) check("rnd_rdy1_no_valid", 1, 0);
            if (bus.req0_valid && bus.req0_ready) exp_q0.push_back(c17(bus.req0_data));
            if (bus.req1_valid && bus.req1_ready) exp_q1.push_back(c17(bus.req1_data));
            if (bus.rsp0_valid && bus.rsp0_ready) begin
                if (exp_q0.size() == 0) check("rnd_q0_empty", 1, 0);
                else begin
                    want = exp_q0.pop_front();
                    check("rnd_d0", bus.rsp0_data, want);
                end
            end
            if (bus.rsp1_valid && bus.rsp1_ready) begin
                if (exp_q1.size() == 0) check("rnd_q1_empty", 1, 0);
                else begin
                    want = exp_q1.pop_front();
                    check("rnd_d1", bus.rsp1_data, want);
                end
            end
            if (exp_q0.size() > DEPTH) check("rnd_ovf0", exp_q0.size(), DEPTH);
            if (exp_q1.size() > DEPTH) check("rnd_ovf1", exp_q1.size(), DEPTH);
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1;
        for (int unsigned c = 0; c < 40; c++) begin
            if (bus.rsp0_valid) begin
                if (exp_q0.size() == 0) check("drn_q0_empty", 1, 0);
                else begin
                    want = exp_q0.pop_front();
                    check("drn_d0", bus.rsp0_data, want);
                end
            end
            if (bus.rsp1_valid) begin
                if (exp_q1.size() == 0) check("drn_q1_empty", 1, 0);
                else begin
                    want = exp_q1.pop_front();
                    check("drn_d1", bus.rsp1_data, want);
                end
            end
            @(negedge clk); #1;
        end
        check("drn_q0_left", exp_q0.size(), 0);
        check("drn_q1_left", exp_q1.size(), 0);
        check("drn_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
